instr_encode: RTL

INSTR_ENCODE -- requirements
Module: instr_encode

---
 rtl/instr_encode.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - instruction field bundle encoder with output FIFO
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          field bundle handshake
//   in_type .. in_off24        instruction field bundle
//   out_valid/out_ready        encoded word handshake, out_instr = FIFO head
//   err                        one-cycle pulse after a rejected bundle
//   err_count, enc_count       saturating reject count, wrapping encode count
module instr_encode #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic [2:0]  in_dp_type,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_opcode,
  input  logic        in_s,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rm,
  input  logic [3:0]  in_rs,
  input  logic [11:0] in_imm12,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_shtype,
  input  logic [4:0]  in_pubwl,
  input  logic [23:0] in_off24,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] enc_count
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic        full;
  logic        accept;
  logic        illegal;
  logic        push;
  logic        pop;
  logic [31:0] enc_word;

  assign full      = (count == FULL_COUNT);
  assign in_ready  = rst_n & ~full;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    illegal = 1'b0;
    if (in_type == 2'b00 || in_cond == 4'hF) begin
      illegal = 1'b1;
    end else if (in_type == 2'b01 &&
                 !(in_dp_type == 3'b001 || in_dp_type == 3'b010 || in_dp_type == 3'b011)) begin
      illegal = 1'b1;
    end
  end

  // Rejected bundles still complete the handshake but never reach the FIFO.
  assign push = accept & ~illegal;

  always_comb begin
    enc_word        = 32'h0;
    enc_word[31:28] = in_cond;
    case (in_type)
      2'b01: begin
        enc_word[27:26] = 2'b00;
        enc_word[24:21] = in_opcode;
        enc_word[20]    = in_s;
        enc_word[19:16] = in_rn;
        enc_word[15:12] = in_rd;
        case (in_dp_type)
          3'b001: begin
            enc_word[25]   = 1'b1;
            enc_word[11:0] = in_imm12;
          end
          3'b010: begin
            enc_word[11:7] = in_shamt;
            enc_word[6:5]  = in_shtype;
            enc_word[3:0]  = in_rm;
          end
          default: begin
            enc_word[11:8] = in_rs;
            enc_word[6:5]  = in_shtype;
            enc_word[4]    = 1'b1;
            enc_word[3:0]  = in_rm;
          end
        endcase
      end
      2'b10: begin
        enc_word[27:26] = 2'b01;
        enc_word[24:20] = in_pubwl;
        enc_word[19:16] = in_rn;
        enc_word[15:12] = in_rd;
        enc_word[11:0]  = in_imm12;
      end
      default: begin
        enc_word[27:26] = 2'b10;
        enc_word[25]    = 1'b1;
        enc_word[24]    = in_pubwl[0];
        enc_word[23:0]  = in_off24;
      end
    endcase
  end

  // Storage needs no reset: out_instr is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
      err_count <= 8'h00;
      enc_count <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      err <= accept & illegal;
      if (accept && illegal && err_count != 8'hFF) begin
        err_count <= err_count + 8'h01;
      end
      if (push) begin
        enc_count <= enc_count + 16'h0001;
      end
    end
  end

endmodule
